window_gen_3x3: RTL and testbench

//  Line-buffered sliding-window generator upstream of the 3x3 convolution stage. Accepts a

---
 rtl/window_gen_3x3.sv | 127 ++++++++++++
 tb/tb_window_gen_3x3.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_gen_3x3.sv
// Sliding 3x3 window generator: two line buffers feed the top/middle rows of a
// 3x3 shift window; each interior position emits one patch through a single
// output register with valid/ready backpressure.
module window_gen_3x3 #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int PIX_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIX_W-1:0]              in_pix,
  input  logic                          in_sof,
  output logic                          patch_valid,
  input  logic                          patch_ready,
  output logic [2:0][2:0][PIX_W-1:0]    patch,
  output logic [$clog2(IMG_H)-1:0]      patch_row,
  output logic [$clog2(IMG_W)-1:0]      patch_col,
  output logic                          frame_done,
  output logic                          sof_err
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);

  typedef enum logic {FILL, RUN} state_e;

  state_e                       state_q, state_d;
  logic [RW-1:0]                r_q, r_d, pr;
  logic [CW-1:0]                c_q, c_d, pc;
  logic [2:0][2:0][PIX_W-1:0]   win_q, win_d, patch_q;
  logic [PIX_W-1:0]             lb_a [IMG_W];
  logic [PIX_W-1:0]             lb_b [IMG_W];
  logic                         patch_valid_q, frame_done_q, sof_err_q;
  logic [RW-1:0]                patch_row_q;
  logic [CW-1:0]                patch_col_q;
  logic                         acc, last_pix, emit;

  assign in_ready    = !patch_valid_q || patch_ready;
  assign patch_valid = patch_valid_q;
  assign patch       = patch_q;
  assign patch_row   = patch_row_q;
  assign patch_col   = patch_col_q;
  assign frame_done  = frame_done_q;
  assign sof_err     = sof_err_q;

  // Next position/state, window shift and emit decision for the pixel being accepted.
  // A start-of-frame pixel is treated as (0,0) regardless of the counters.
  always_comb begin
    acc      = in_valid && in_ready;
    pr       = in_sof ? '0 : r_q;
    pc       = in_sof ? '0 : c_q;
    last_pix = (pr == R_LAST) && (pc == C_LAST);
    r_d      = r_q;
    c_d      = c_q;
    state_d  = state_q;
    win_d    = win_q;
    emit     = 1'b0;
    if (acc) begin
      if (pc == C_LAST) begin
        c_d = '0;
        r_d = last_pix ? '0 : pr + RW'(1);
      end else begin
        c_d = pc + CW'(1);
        r_d = pr;
      end
      if (in_sof)
        state_d = FILL;
      else if (state_q == FILL && pr == RW'(1) && pc == C_LAST)
        state_d = RUN;
      else if (state_q == RUN && last_pix)
        state_d = FILL;
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb_b[pc];
      win_d[1][2] = lb_a[pc];
      win_d[2][2] = in_pix;
      // Columns 0/1 would mix pixels across the line wrap, so they never emit.
      emit = !in_sof && (state_q == RUN) && (pc >= CW'(2));
    end
  end

  // Counters, state, window and the output register with backpressure hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      r_q           <= '0;
      c_q           <= '0;
      win_q         <= '0;
      patch_q       <= '0;
      patch_row_q   <= '0;
      patch_col_q   <= '0;
      patch_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      sof_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      win_q        <= win_d;
      frame_done_q <= acc && last_pix;
      if (acc && in_sof && (r_q != '0 || c_q != '0))
        sof_err_q <= 1'b1;
      if (emit) begin
        patch_valid_q <= 1'b1;
        patch_q       <= win_d;
        patch_row_q   <= r_q - RW'(2);
        patch_col_q   <= c_q - CW'(2);
      end else if (patch_ready) begin
        patch_valid_q <= 1'b0;
      end
    end
  end

  // Line buffers: B takes the previous row from A, A takes the incoming pixel.
  // Stale contents after reset are harmless because FILL suppresses output.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb_b[pc] <= lb_a[pc];
      lb_a[pc] <= in_pix;
    end
  end
endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 5x4 frame with pixel(r,c) = 5r+c+1.
module tb_window_gen_3x3;
  localparam int W = 5, H = 4, PW = 8;
  typedef logic [2:0][2:0][PW-1:0] patch_t;
  typedef struct { patch_t p; int row; int col; } obs_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_sof, patch_valid, patch_ready, frame_done, sof_err;
  logic [PW-1:0] in_pix;
  patch_t patch;
  logic [1:0] patch_row;
  logic [2:0] patch_col;

  int passed = 0, total = 0, fd_cnt = 0;
  obs_t q[$];

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .in_sof(in_sof), .patch_valid(patch_valid), .patch_ready(patch_ready), .patch(patch),
    .patch_row(patch_row), .patch_col(patch_col), .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  // Record every patch handshake and frame_done pulse (sampled mid-cycle).
  always @(negedge clk) begin
    if (!rst && patch_valid && patch_ready) begin
      obs_t o;
      o.p = patch; o.row = int'(patch_row); o.col = int'(patch_col);
      q.push_back(o);
    end
    if (!rst && frame_done) fd_cnt++;
  end

  function automatic patch_t mdl(input int r, input int c);
    patch_t p;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = PW'(5 * (r + i) + (c + j) + 1);
    return p;
  endfunction

  function automatic patch_t pat(input int a0, a1, a2, b0, b1, b2, c0, c1, c2);
    patch_t p;
    p[0][0] = PW'(a0); p[0][1] = PW'(a1); p[0][2] = PW'(a2);
    p[1][0] = PW'(b0); p[1][1] = PW'(b1); p[1][2] = PW'(b2);
    p[2][0] = PW'(c0); p[2][1] = PW'(c1); p[2][2] = PW'(c2);
    return p;
  endfunction

  // Drive one pixel until accepted; returns 1 ns after the accepting edge.
  task automatic send_pix(input int v, input logic sof);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1; in_pix = PW'(v); in_sof = sof;
    while (!acc) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 100) begin
        total++;
        $display("FAIL send_timeout: pixel %0d not accepted within %0d cycles", v, n);
        break;
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input bit sof_first);
    for (int v = 1; v <= 20; v++) begin
      if (gaps) begin
        int g = 0;
        while ($urandom_range(0, 1) == 1 && g < 4) begin
          @(posedge clk); #1; g++;
        end
      end
      send_pix(v, sof_first && v == 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; patch_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; patch_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (patch_valid !== 1'b0) $display("FAIL rst_pv: got %b want 0", patch_valid); else passed++;
    total++; if (patch !== '0) $display("FAIL rst_patch: got %h want 0", patch); else passed++;
    total++; if (patch_row !== '0 || patch_col !== '0) $display("FAIL rst_rc: got %0d,%0d want 0,0", patch_row, patch_col); else passed++;
    total++; if (frame_done !== 1'b0 || sof_err !== 1'b0) $display("FAIL rst_flags: got fd %b se %b want 0 0", frame_done, sof_err); else passed++;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_full_frame();
    int qb;
    do_reset();
    qb = q.size();
    for (int v = 1; v <= 12; v++) send_pix(v, 1'b0);
    total++; if (patch_valid !== 1'b0) $display("FAIL s1_fill_quiet: got pv %b want 0", patch_valid); else passed++;
    send_pix(13, 1'b0);
    total++; if (patch_valid !== 1'b1) $display("FAIL s1_latency: got pv %b want 1", patch_valid); else passed++;
    total++; if (patch !== pat(1,2,3,6,7,8,11,12,13) || patch_row !== 2'd0 || patch_col !== 3'd0)
      $display("FAIL s1_first: got r%0d c%0d %h want r0 c0 %h", patch_row, patch_col, patch, pat(1,2,3,6,7,8,11,12,13));
    else passed++;
    for (int v = 14; v <= 20; v++) send_pix(v, 1'b0);
    total++; if (patch !== pat(8,9,10,13,14,15,18,19,20) || patch_row !== 2'd1 || patch_col !== 3'd2)
      $display("FAIL s1_last: got r%0d c%0d %h want r1 c2 %h", patch_row, patch_col, patch, pat(8,9,10,13,14,15,18,19,20));
    else passed++;
    total++; if (frame_done !== 1'b1) $display("FAIL s1_fd_pulse: got %b want 1", frame_done); else passed++;
    @(posedge clk); #1;
    total++; if (frame_done !== 1'b0) $display("FAIL s1_fd_clear: got %b want 0", frame_done); else passed++;
    total++; if (q.size() - qb != 6) $display("FAIL s1_count: got %0d want 6", q.size() - qb); else passed++;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (qb + k >= q.size()) $display("FAIL s1_patch%0d: missing, want r%0d c%0d", k, k / 3, k % 3);
      else if (q[qb+k].p !== mdl(k / 3, k % 3) || q[qb+k].row != k / 3 || q[qb+k].col != k % 3)
        $display("FAIL s1_patch%0d: got r%0d c%0d %h want r%0d c%0d %h", k, q[qb+k].row, q[qb+k].col, q[qb+k].p, k / 3, k % 3, mdl(k / 3, k % 3));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int qb = q.size();
    for (int v = 1; v <= 14; v++) send_pix(v, 1'b0);
    patch_ready = 1'b0; in_valid = 1'b1; in_pix = 8'd15;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) $display("FAIL s2_ready%0d: got %b want 0", k, in_ready); else passed++;
      total++; if (patch_valid !== 1'b1 || patch !== pat(2,3,4,7,8,9,12,13,14) || patch_col !== 3'd1)
        $display("FAIL s2_hold%0d: got pv %b c%0d %h want 1 c1 %h", k, patch_valid, patch_col, patch, pat(2,3,4,7,8,9,12,13,14));
      else passed++;
      @(posedge clk); #1;
    end
    patch_ready = 1'b1;
    send_pix(15, 1'b0);
    total++; if (patch !== pat(3,4,5,8,9,10,13,14,15) || patch_row !== 2'd0 || patch_col !== 3'd2)
      $display("FAIL s2_resume: got r%0d c%0d %h want r0 c2 %h", patch_row, patch_col, patch, pat(3,4,5,8,9,10,13,14,15));
    else passed++;
    for (int v = 16; v <= 20; v++) send_pix(v, 1'b0);
    repeat (2) @(posedge clk); #1;
    total++; if (q.size() - qb != 6) $display("FAIL s2_count: got %0d want 6", q.size() - qb); else passed++;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (qb + k >= q.size()) $display("FAIL s2_patch%0d: missing", k);
      else if (q[qb+k].p !== mdl(k / 3, k % 3) || q[qb+k].row != k / 3 || q[qb+k].col != k % 3)
        $display("FAIL s2_patch%0d: got r%0d c%0d %h want r%0d c%0d %h", k, q[qb+k].row, q[qb+k].col, q[qb+k].p, k / 3, k % 3, mdl(k / 3, k % 3));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int qb = q.size();
    int fd0 = fd_cnt;
    send_frame(1'b0, 1'b1);
    total++; if (frame_done !== 1'b1) $display("FAIL s3_fd1: got %b want 1", frame_done); else passed++;
    send_frame(1'b0, 1'b1);
    total++; if (frame_done !== 1'b1) $display("FAIL s3_fd2: got %b want 1", frame_done); else passed++;
    repeat (2) @(posedge clk); #1;
    total++; if (fd_cnt - fd0 != 2) $display("FAIL s3_fd_count: got %0d want 2", fd_cnt - fd0); else passed++;
    total++; if (sof_err !== 1'b0) $display("FAIL s3_sof_ok: got %b want 0", sof_err); else passed++;
    total++; if (q.size() - qb != 12) $display("FAIL s3_count: got %0d want 12", q.size() - qb); else passed++;
    for (int k = 0; k < 12; k++) begin
      total++;
      if (qb + k >= q.size()) $display("FAIL s3_patch%0d: missing", k);
      else if (q[qb+k].p !== mdl((k % 6) / 3, k % 3) || q[qb+k].row != (k % 6) / 3 || q[qb+k].col != k % 3)
        $display("FAIL s3_patch%0d: got r%0d c%0d %h want r%0d c%0d %h", k, q[qb+k].row, q[qb+k].col, q[qb+k].p, (k % 6) / 3, k % 3, mdl((k % 6) / 3, k % 3));
      else passed++;
    end
  endtask

  task automatic test_sof_resync();
    int qb;
    for (int v = 1; v <= 13; v++) send_pix(v, 1'b0);
    send_pix(1, 1'b1);
    qb = q.size();
    total++; if (sof_err !== 1'b1) $display("FAIL s5_sof_err: got %b want 1", sof_err); else passed++;
    for (int v = 2; v <= 20; v++) send_pix(v, 1'b0);
    repeat (2) @(posedge clk); #1;
    total++; if (sof_err !== 1'b1) $display("FAIL s5_sticky: got %b want 1", sof_err); else passed++;
    total++; if (q.size() - qb != 6) $display("FAIL s5_count: got %0d want 6", q.size() - qb); else passed++;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (qb + k >= q.size()) $display("FAIL s5_patch%0d: missing", k);
      else if (q[qb+k].p !== mdl(k / 3, k % 3) || q[qb+k].row != k / 3 || q[qb+k].col != k % 3)
        $display("FAIL s5_patch%0d: got r%0d c%0d %h want r%0d c%0d %h", k, q[qb+k].row, q[qb+k].col, q[qb+k].p, k / 3, k % 3, mdl(k / 3, k % 3));
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    int qb;
    for (int v = 1; v <= 12; v++) send_pix(v, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (patch_valid !== 1'b0 || patch !== '0 || patch_row !== '0 || patch_col !== '0)
      $display("FAIL s4_outs: got pv %b r%0d c%0d %h want all 0", patch_valid, patch_row, patch_col, patch);
    else passed++;
    total++; if (sof_err !== 1'b0 || frame_done !== 1'b0) $display("FAIL s4_flags: got se %b fd %b want 0 0", sof_err, frame_done); else passed++;
    rst = 1'b0;
    qb = q.size();
    send_frame(1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;
    total++; if (q.size() - qb != 6) $display("FAIL s4_count: got %0d want 6", q.size() - qb); else passed++;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (qb + k >= q.size()) $display("FAIL s4_patch%0d: missing", k);
      else if (q[qb+k].p !== mdl(k / 3, k % 3) || q[qb+k].row != k / 3 || q[qb+k].col != k % 3)
        $display("FAIL s4_patch%0d: got r%0d c%0d %h want r%0d c%0d %h", k, q[qb+k].row, q[qb+k].col, q[qb+k].p, k / 3, k % 3, mdl(k / 3, k % 3));
      else passed++;
    end
  endtask

  task automatic test_random_valid();
    int qb = q.size();
    send_frame(1'b1, 1'b0);
    repeat (2) @(posedge clk); #1;
    total++; if (q.size() - qb != 6) $display("FAIL s6_count: got %0d want 6", q.size() - qb); else passed++;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (qb + k >= q.size()) $display("FAIL s6_patch%0d: missing", k);
      else if (q[qb+k].p !== mdl(k / 3, k % 3) || q[qb+k].row != k / 3 || q[qb+k].col != k % 3)
        $display("FAIL s6_patch%0d: got r%0d c%0d %h want r%0d c%0d %h", k, q[qb+k].row, q[qb+k].col, q[qb+k].p, k / 3, k % 3, mdl(k / 3, k % 3));
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; patch_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_back_to_back();
    test_sof_resync();
    test_mid_reset();
    test_random_valid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
